osd_console: RTL and testbench
==============================

Name: osd_console

Overview:
- Upstream feeder for the OSD text-mode controller: turns a byte stream (characters plus control codes) into writes on the screen buffer's port B (address, data, wren).
- Keeps a cursor over the 32x8 text window, an inverse-video attribute, and a hardware clear-screen sequencer.
- Sits between the OSD host (the CPU-side OSD register or the keyboard menu logic) and the screen buffer.

Parameters:
- COLS, 32, text columns; must be a power of 2.
- ROWS, 8, text rows; must be a power of 2.
- ADDR_W, 8, buffer address width; equals log2(COLS*ROWS).
- BLANK, 8'h20, fill code written by clear.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- ce  in  1  clock enable; all state advances only on clk edges with ce=1
- in_data  in  8  character or control code
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts in_data this ce cycle
- wr_addr  out  ADDR_W  screen buffer address, to textmode address
- wr_data  out  8  screen buffer data, to textmode data
- wr_en  out  1  screen buffer write strobe, to textmode wren
- cursor_x  out  5  current column
- cursor_y  out  3  current row
- busy  out  1  clear sequence in progress

Behaviour:
- **Clock and reset:** one clock, clk. reset_n is asynchronous and active-low.
- **Reset values:** state=CLEAR, clr_cnt=0, cursor_x=0, cursor_y=0, inverse=0, wr_en=0, wr_addr=0, wr_data=BLANK, in_ready=0, busy=1. Reset therefore always blanks the screen.
- **States:**
  - IDLE: in_ready=1, busy=0.
  - CLEAR: in_ready=0, busy=1.
  - in_ready and busy are decoded from registered state only, never from in_valid.
- **Accept condition:** ce & in_valid & in_ready, in IDLE only. The host holds in_data/in_valid until accepted.
- **Write output timing:** wr_addr, wr_data and wr_en are registered. A write produced on an accepting or clearing ce edge appears with wr_en=1 for exactly one clk cycle after that edge (latency 1 clk). wr_en is 0 on every other cycle, including when ce is low.
- **Cell address:** cursor_y*COLS + cursor_x, i.e. {cursor_y, cursor_x}, using the cursor value before it advances.
- **Printable input (in_data >= 0x20, including >= 0x80):**
  - wr_data = {in_data[7] | inverse, in_data[6:0]}.
  - Then advance the cursor: x+1. At x=COLS-1, x=0 and y=(y+1) mod ROWS.
  - At row ROWS-1 the cursor wraps to row 0. There is no scrolling.
- **Control codes:** accepted in one ce cycle, no buffer write.
  - 0x0D CR: x=0.
  - 0x0A LF: y=(y+1) mod ROWS; x unchanged.
  - 0x08 BS: x>0 gives x-1. At x=0, x=COLS-1 and y=(y-1) mod ROWS.
  - 0x1E HOME: x=0, y=0.
  - 0x0E SO: inverse=1. 0x0F SI: inverse=0.
  - 0x0C FF: go to CLEAR with clr_cnt=0, inverse=0.
  - Any other code < 0x20: consumed, no effect.
- **CLEAR sequence:**
  - Each ce cycle issues a write with addr=clr_cnt, data=BLANK, then clr_cnt+1.
  - The write for clr_cnt=COLS*ROWS-1 transitions to IDLE with cursor (0,0).
  - Duration: exactly COLS*ROWS (256) ce cycles. in_valid is ignored throughout.
- **ce low:** everything is frozen, with no state, cursor or counter change. wr_en drops to 0 after its one-cycle pulse.
- **Reset asserted mid-operation:** any clear in progress is abandoned, a pending write pulse is dropped, and a fresh full clear runs from address 0 after release.
- **Arithmetic:** cursor and clr_cnt arithmetic wraps modulo field width. No saturating logic.

Decomposition:
- Package osd_pkg holds:
  - COLS, ROWS, ADDR_W, BLANK;
  - control code constants CC_CR, CC_LF, CC_BS, CC_FF, CC_HOME, CC_SO, CC_SI;
  - state encoding ST_IDLE, ST_CLEAR.
- One sub-module, osd_cursor: holds the x/y registers and applies the ops none/advance/cr/lf/bs/home/zero, with wrap rules. It is purely sequential under ce.
- The top level holds the FSM, the clear counter, the inverse flag and the write register.

Test Plan:
- **Reset then idle:** release reset_n, ce=1 constantly. Expect 256 writes, addr 0..255, data 0x20, then in_ready=1, busy=0, cursor (0,0).
- **Printable and wrap:** send "AB", then 30 bytes of 0x41. Expect writes (0,0x41),(1,0x42),... up to addr 31, then cursor (0,1). Next 'C' goes to addr 32.
- **Inverse:** send SO,'A',SI,'A'. Expect data 0xC1 at addr 0 and 0x41 at addr 1. The SO and SI bytes produce no wr_en.
- **Controls at boundaries:**
  - From (0,0), BS gives (31,7). CR gives (0,7). LF gives (0,0).
  - From (5,3), HOME gives (0,0).
  - Byte 0x01 is accepted with no write and no cursor change.
- **FF with ce gating:** issue FF with ce toggling 1/0. Expect exactly 256 single-cycle wr_en pulses, in_ready low throughout, and in_valid='X' held during the clear is not consumed.
- **Reset mid-clear:** assert reset_n=0 at clr_cnt=100. Expect wr_en=0 immediately, then after release a fresh clear starting at addr 0.

Source files
------------

// File: rtl/osd_pkg.sv
// osd_pkg: shared geometry, control codes and state encodings for the OSD console.
package osd_pkg;
    localparam int COLS = 32;
    localparam int ROWS = 8;
    localparam int ADDR_W = 8;
    localparam int X_W = $clog2(COLS);
    localparam int Y_W = $clog2(ROWS);
    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;
    localparam logic [7:0] CC_SO = 8'h0E;
    localparam logic [7:0] CC_SI = 8'h0F;
    localparam logic [7:0] CC_HOME = 8'h1E;
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
    typedef enum logic [2:0] {OP_NONE, OP_ADV, OP_CR, OP_LF, OP_BS, OP_HOME, OP_ZERO} cur_op_t;
endpackage

// File: rtl/osd_if.sv
// osd_if: host byte stream, screen-buffer write port and status of the OSD console.
//   master: host side (drives ce, in_data, in_valid)
//   slave : console side (drives in_ready, wr_*, cursor_*, busy)
interface osd_if;
    import osd_pkg::*;
    logic ce;
    logic [7:0] in_data;
    logic in_valid;
    logic in_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0] wr_data;
    logic wr_en;
    logic [X_W-1:0] cursor_x;
    logic [Y_W-1:0] cursor_y;
    logic busy;
    modport master (
        output ce, in_data, in_valid,
        input in_ready, wr_addr, wr_data, wr_en, cursor_x, cursor_y, busy
    );
    modport slave (
        input ce, in_data, in_valid,
        output in_ready, wr_addr, wr_data, wr_en, cursor_x, cursor_y, busy
    );
endinterface

// File: rtl/osd_cursor.sv
// osd_cursor: text cursor x/y registers with wrap-around cursor operations.
//   clk, reset_n : clock, async active-low reset
//   ce_i         : clock enable
//   op_i         : cursor operation applied on a ce edge
//   x_o, y_o     : current column / row
module osd_cursor
    import osd_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ce_i,
    input  cur_op_t        op_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o
);
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    // Field widths match the window size, so plain +/- 1 gives the wrap.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        case (op_i)
            OP_ADV: begin
                x_d = x_q + X_W'(1);
                y_d = (x_q == X_W'(COLS - 1)) ? y_q + Y_W'(1) : y_q;
            end
            OP_CR: x_d = '0;
            OP_LF: y_d = y_q + Y_W'(1);
            OP_BS: begin
                x_d = x_q - X_W'(1);
                y_d = (x_q == '0) ? y_q - Y_W'(1) : y_q;
            end
            OP_HOME, OP_ZERO: begin
                x_d = '0;
                y_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (ce_i) begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;
endmodule

// File: rtl/osd_console.sv
// osd_console: turns a character/control byte stream into screen-buffer writes.
//   clk, reset_n : clock, async active-low reset (reset always runs a full clear)
//   bus          : osd_if slave -- ce, in_data/in_valid/in_ready, wr_addr/wr_data/wr_en,
//                  cursor_x/cursor_y, busy
module osd_console
    import osd_pkg::*;
(
    input logic clk,
    input logic reset_n,
    osd_if.slave bus
);
    state_t state_q, state_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    logic inv_q, inv_d;
    logic wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    cur_op_t op;
    logic [X_W-1:0] cur_x;
    logic [Y_W-1:0] cur_y;

    osd_cursor u_cursor (
        .clk(clk),
        .reset_n(reset_n),
        .ce_i(bus.ce),
        .op_i(op),
        .x_o(cur_x),
        .y_o(cur_y)
    );

    // wr_en defaults low every cycle so each write is a single-cycle pulse,
    // even when ce stays low afterwards.
    always_comb begin
        state_d = state_q;
        clr_d = clr_q;
        inv_d = inv_q;
        wr_en_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        op = OP_NONE;
        if (bus.ce) begin
            if (state_q == ST_CLEAR) begin
                wr_en_d = 1'b1;
                wr_addr_d = clr_q;
                wr_data_d = BLANK;
                clr_d = clr_q + ADDR_W'(1);
                if (clr_q == '1) begin
                    state_d = ST_IDLE;
                    op = OP_ZERO;
                end
            end else if (bus.in_valid) begin
                if (bus.in_data >= 8'h20) begin
                    wr_en_d = 1'b1;
                    wr_addr_d = {cur_y, cur_x};
                    wr_data_d = {bus.in_data[7] | inv_q, bus.in_data[6:0]};
                    op = OP_ADV;
                end else begin
                    case (bus.in_data)
                        CC_CR:   op = OP_CR;
                        CC_LF:   op = OP_LF;
                        CC_BS:   op = OP_BS;
                        CC_HOME: op = OP_HOME;
                        CC_SO:   inv_d = 1'b1;
                        CC_SI:   inv_d = 1'b0;
                        CC_FF: begin
                            state_d = ST_CLEAR;
                            clr_d = '0;
                            inv_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            clr_q <= '0;
            inv_q <= 1'b0;
            wr_en_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= BLANK;
        end else begin
            state_q <= state_d;
            clr_q <= clr_d;
            inv_q <= inv_d;
            wr_en_q <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.in_ready = (state_q == ST_IDLE);
    assign bus.busy = (state_q == ST_CLEAR);
    assign bus.wr_en = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.cursor_x = cur_x;
    assign bus.cursor_y = cur_y;
endmodule

// File: tb/tb_osd_console.sv
// tb_osd_console: directed self-checking bench for osd_console.
module tb_osd_console;
    logic clk = 1'b0;
    logic reset_n;
    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] wq[$];
    int run = 0;
    int maxrun = 0;

    osd_if bus ();

    osd_console dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wq.push_back({bus.wr_addr, bus.wr_data});
            run++;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic got;
        got = 1'b0;
        bus.in_data = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 1000 && !got; i++) begin
            got = bus.ce && bus.in_ready;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("send_accept", {31'd0, got}, 32'd1);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 2000 && bus.busy; i++) @(negedge clk);
        check(tag, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic check_cursor(input string tag, input int x, input int y);
        check(tag, {24'd0, bus.cursor_y, bus.cursor_x}, {24'd0, 3'(y), 5'(x)});
    endtask

    task automatic check_clear(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 256 && i < wq.size(); i++)
            if (wq[i] !== {8'(i), 8'h20}) bad++;
        check({tag, "_count"}, wq.size(), 256);
        check({tag, "_seq"}, bad, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.ce = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 0);
        check("rst_busy", {31'd0, bus.busy}, 1);
        check("rst_wr_en", {31'd0, bus.wr_en}, 0);
        check("rst_wr_addr", {24'd0, bus.wr_addr}, 0);
        check("rst_wr_data", {24'd0, bus.wr_data}, 32'h20);
        check_cursor("rst_cursor", 0, 0);
        wq.delete();
        reset_n = 1'b1;
        wait_idle("init_idle");
        settle();
        check_clear("init_clear");
        check("init_in_ready", {31'd0, bus.in_ready}, 1);
        check_cursor("init_cursor", 0, 0);

        wq.delete();
        send(8'h41);
        send(8'h42);
        for (int i = 0; i < 30; i++) send(8'h41);
        settle();
        check("prn_count", wq.size(), 32);
        check("prn_w0", {16'd0, wq[0]}, 32'h0041);
        check("prn_w1", {16'd0, wq[1]}, 32'h0142);
        check("prn_w31", {16'd0, wq[31]}, 32'h1F41);
        check_cursor("prn_wrap_cursor", 0, 1);
        send(8'h43);
        settle();
        check("prn_w32", {16'd0, wq[32]}, 32'h2043);
        check_cursor("prn_after_c", 1, 1);

        send(8'h1E);
        settle();
        check_cursor("home1", 0, 0);
        wq.delete();
        send(8'h0E);
        send(8'h41);
        send(8'h0F);
        send(8'h41);
        send(8'hC1);
        settle();
        check("inv_count", wq.size(), 3);
        check("inv_w0", {16'd0, wq[0]}, 32'h00C1);
        check("inv_w1", {16'd0, wq[1]}, 32'h0141);
        check("hi_w2", {16'd0, wq[2]}, 32'h02C1);

        send(8'h1E);
        wq.delete();
        send(8'h08);
        settle();
        check_cursor("bs_wrap", 31, 7);
        send(8'h0D);
        settle();
        check_cursor("cr", 0, 7);
        send(8'h0A);
        settle();
        check_cursor("lf_wrap", 0, 0);
        for (int i = 0; i < 3; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h2E);
        settle();
        check_cursor("pos_5_3", 5, 3);
        send(8'h08);
        settle();
        check_cursor("bs_mid", 4, 3);
        send(8'h2E);
        send(8'h1E);
        settle();
        check_cursor("home2", 0, 0);
        check("ctl_writes", wq.size(), 6);
        wq.delete();
        send(8'h01);
        settle();
        check("c01_nowrite", wq.size(), 0);
        check_cursor("c01_cursor", 0, 0);
        check("c01_ready", {31'd0, bus.in_ready}, 1);

        send(8'h0E);
        send(8'h0C);
        begin
            int ce_hi, bad;
            ce_hi = 0;
            bad = 0;
            wq.delete();
            maxrun = 0;
            bus.in_data = 8'h58;
            bus.in_valid = 1'b1;
            for (int i = 0; i < 2000 && bus.busy; i++) begin
                if (bus.in_ready) bad++;
                bus.ce = ~bus.ce;
                if (bus.ce) ce_hi++;
                @(negedge clk);
            end
            bus.in_valid = 1'b0;
            bus.ce = 1'b1;
            check("ff_idle", {31'd0, bus.busy}, 0);
            check("ff_ce_edges", ce_hi, 256);
            check("ff_ready_low", bad, 0);
        end
        settle();
        check_clear("ff_clear");
        check("ff_pulse_len", maxrun, 1);
        check_cursor("ff_cursor", 0, 0);
        send(8'h41);
        settle();
        check("ff_inv_off", {16'd0, wq[256]}, 32'h0041);

        send(8'h0C);
        repeat (100) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_wr_en", {31'd0, bus.wr_en}, 0);
        check("mid_rst_addr", {24'd0, bus.wr_addr}, 0);
        check("mid_rst_busy", {31'd0, bus.busy}, 1);
        repeat (3) @(negedge clk);
        wq.delete();
        reset_n = 1'b1;
        wait_idle("mid_idle");
        settle();
        check_clear("mid_clear");
        check_cursor("mid_cursor", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
